// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: two-port round-robin arbiter onto a single-command SDRAM controller host port.
// Define ARB_STATS_EN to build the per-port saturating ack counters (p0_count/p1_count).
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH   = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int ISSUE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic                   p0_ack,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]  p1_wdata,
  output logic                   p1_ack,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [DATA_WIDTH-1:0]  sd_wr_data,
  output logic                   sd_wr_enable,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic                   sd_rd_enable,
  input  logic [DATA_WIDTH-1:0]  sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_busy,
  output logic                   timeout_err,
  output logic [15:0]            p0_count,
  output logic [15:0]            p1_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  localparam logic [7:0] TMO = 8'(ISSUE_TIMEOUT);
  state_t state;
  logic owner, last_grant, is_wr;
  logic [7:0] cnt;
  logic sel, sel_we, done;
  always_comb begin
    sel    = (p0_req && p1_req) ? ~last_grant : p1_req;
    sel_we = sel ? p1_we : p0_we;
    done   = is_wr ? !sd_busy : sd_rd_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      is_wr        <= 1'b0;
      cnt          <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      sd_wr_addr   <= '0;
      sd_rd_addr   <= '0;
      sd_wr_data   <= '0;
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: if (!sd_busy && (p0_req || p1_req)) begin
          owner        <= sel;
          is_wr        <= sel_we;
          sd_wr_addr   <= sel ? p1_addr : p0_addr;
          sd_rd_addr   <= sel ? p1_addr : p0_addr;
          sd_wr_data   <= sel ? p1_wdata : p0_wdata;
          sd_wr_enable <= sel_we;
          sd_rd_enable <= !sel_we;
          cnt          <= '0;
          state        <= ISSUE;
        end
        // enables stay up until the controller shows it accepted the command
        ISSUE: if (sd_busy) begin
          sd_wr_enable <= 1'b0;
          sd_rd_enable <= 1'b0;
          state        <= WAIT_DONE;
        end else begin
          if (cnt != TMO) cnt <= cnt + 8'd1;
          if (cnt >= TMO - 8'd1) timeout_err <= 1'b1;
        end
        WAIT_DONE: if (done) begin
          if (!is_wr && !owner) p0_rdata <= sd_rd_data;
          if (!is_wr && owner) p1_rdata <= sd_rd_data;
          p0_ack     <= !owner;
          p1_ack     <= owner;
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_count <= '0;
      p1_count <= '0;
    end else begin
      if (p0_ack && p0_count != 16'hFFFF) p0_count <= p0_count + 16'd1;
      if (p1_ack && p1_count != 16'hFFFF) p1_count <= p1_count + 16'd1;
    end
  end
`else
  assign p0_count = '0;
  assign p1_count = '0;
`endif
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter: directed vector table plus init, timeout and async-reset sequences.
module tb_sdram_host_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [23:0] p0_addr = 24'h000010, p1_addr = 24'h000020;
  logic [15:0] p0_wdata = 16'hAAAA, p1_wdata = 16'h5555;
  logic p0_ack, p1_ack, sd_wr_enable, sd_rd_enable, timeout_err;
  logic [15:0] p0_rdata, p1_rdata, sd_wr_data, p0_count, p1_count;
  logic [23:0] sd_wr_addr, sd_rd_addr;
  logic [15:0] sd_rd_data = '0;
  logic sd_rd_ready = 0, sd_busy = 0;
  int checks = 0, errors = 0;

  sdram_host_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable), .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy), .timeout_err(timeout_err),
    .p0_count(p0_count), .p1_count(p1_count)
  );

  always #5 clk = ~clk;

  // in = {p0_req,p0_we,p1_req,p1_we,busy,rd_ready}; en = {wr_en,rd_en}; ack = {p1_ack,p0_ack}
  typedef struct {
    logic [5:0]  in;
    logic [15:0] rd;
    logic [1:0]  en;
    logic [23:0] addr;
    logic [1:0]  ack;
    logic [15:0] d0;
    logic [15:0] d1;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ok;
    tbl[0]  = '{6'b101000, 16'h0000, 2'b01, 24'h10, 2'b00, 16'h0000, 16'h0000};
    tbl[1]  = '{6'b101000, 16'h0000, 2'b01, 24'h10, 2'b00, 16'h0000, 16'h0000};
    tbl[2]  = '{6'b101010, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h0000, 16'h0000};
    tbl[3]  = '{6'b101010, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h0000, 16'h0000};
    tbl[4]  = '{6'b101011, 16'h1111, 2'b00, 24'h10, 2'b01, 16'h1111, 16'h0000};
    tbl[5]  = '{6'b101010, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h1111, 16'h0000};
    tbl[6]  = '{6'b101000, 16'h0000, 2'b01, 24'h20, 2'b00, 16'h1111, 16'h0000};
    tbl[7]  = '{6'b101010, 16'h0000, 2'b00, 24'h20, 2'b00, 16'h1111, 16'h0000};
    tbl[8]  = '{6'b101011, 16'h2222, 2'b00, 24'h20, 2'b10, 16'h1111, 16'h2222};
    tbl[9]  = '{6'b111000, 16'h0000, 2'b10, 24'h10, 2'b00, 16'h1111, 16'h2222};
    tbl[10] = '{6'b111010, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h1111, 16'h2222};
    tbl[11] = '{6'b111010, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h1111, 16'h2222};
    tbl[12] = '{6'b111000, 16'h0000, 2'b00, 24'h10, 2'b01, 16'h1111, 16'h2222};
    tbl[13] = '{6'b111000, 16'h0000, 2'b01, 24'h20, 2'b00, 16'h1111, 16'h2222};
    tbl[14] = '{6'b110010, 16'h0000, 2'b00, 24'h20, 2'b00, 16'h1111, 16'h2222};
    tbl[15] = '{6'b110011, 16'h3333, 2'b00, 24'h20, 2'b10, 16'h1111, 16'h3333};
    tbl[16] = '{6'b110000, 16'h0000, 2'b10, 24'h10, 2'b00, 16'h1111, 16'h3333};
    tbl[17] = '{6'b110010, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h1111, 16'h3333};
    tbl[18] = '{6'b110000, 16'h0000, 2'b00, 24'h10, 2'b01, 16'h1111, 16'h3333};
    tbl[19] = '{6'b000000, 16'h0000, 2'b00, 24'h10, 2'b00, 16'h1111, 16'h3333};

    step; step;
    chk("reset_outputs", {sd_wr_enable, sd_rd_enable, p0_ack, p1_ack, timeout_err, sd_wr_addr, sd_rd_addr, sd_wr_data, p0_rdata, p1_rdata},
        {5'b0, 24'h0, 24'h0, 16'h0, 16'h0, 16'h0});
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      {p0_req, p0_we, p1_req, p1_we, sd_busy, sd_rd_ready} = tbl[i].in;
      sd_rd_data = tbl[i].rd;
      step;
      chk($sformatf("vec%0d", i), {sd_wr_enable, sd_rd_enable, sd_wr_addr, sd_rd_addr, p1_ack, p0_ack, p0_rdata, p1_rdata},
          {tbl[i].en, tbl[i].addr, tbl[i].addr, tbl[i].ack, tbl[i].d0, tbl[i].d1});
    end
`ifdef ARB_STATS_EN
    chk("stats_counts", {p0_count, p1_count}, {16'd3, 16'd2});
`else
    chk("stats_counts", {p0_count, p1_count}, {16'd0, 16'd0});
`endif

    // controller init: busy stays low for 30 cycles while the write is presented
    p0_addr = 24'h012345; p0_wdata = 16'hBEEF; p0_req = 1; p0_we = 1; sd_busy = 0;
    step;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step;
      if (!(sd_wr_enable && !sd_rd_enable && sd_wr_addr == 24'h012345 && sd_wr_data == 16'hBEEF && !timeout_err && !p0_ack)) ok = 1'b0;
    end
    chk("init_hold", ok, 1'b1);
    sd_busy = 1;
    step;
    chk("init_accept", {sd_wr_enable, p0_ack}, 2'b00);
    step;
    sd_busy = 0;
    step;
    chk("init_ack", {p0_ack, p1_ack, timeout_err}, 3'b100);
    p0_req = 0;
    step;
    chk("init_ack_once", {p0_ack, sd_wr_enable, sd_rd_enable}, 3'b000);

    // controller never raises busy: timeout after exactly ISSUE_TIMEOUT cycles in ISSUE
    p1_req = 1; p1_we = 0;
    step;
    chk("tmo_grant", {sd_rd_enable, sd_rd_addr}, {1'b1, 24'h20});
    for (int k = 1; k <= 255; k++) begin
      step;
      if (k == 254) chk("tmo_before", timeout_err, 1'b0);
      if (k == 255) chk("tmo_at", timeout_err, 1'b1);
    end
    repeat (5) step;
    chk("tmo_sticky", {timeout_err, sd_rd_enable}, 2'b11);
    sd_busy = 1;
    step;
    p1_req = 0; sd_rd_ready = 1; sd_rd_data = 16'h4444;
    step;
    chk("tmo_complete", {p1_ack, p1_rdata, timeout_err}, {1'b1, 16'h4444, 1'b1});
    sd_rd_ready = 0; sd_busy = 0;
    step;

    // reset asserted while a p0 read waits for data
    p0_addr = 24'h000010; p0_req = 1; p0_we = 0;
    step;
    chk("rst_pre_grant", {sd_rd_enable, sd_rd_addr}, {1'b1, 24'h10});
    sd_busy = 1;
    step;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {sd_wr_enable, sd_rd_enable, p0_ack, p1_ack, timeout_err, sd_wr_addr, sd_rd_addr, sd_wr_data, p0_rdata, p1_rdata},
        {5'b0, 24'h0, 24'h0, 16'h0, 16'h0, 16'h0});
    p0_req = 0; sd_rd_ready = 1; sd_rd_data = 16'h9999;
    step;
    @(negedge clk);
    rst_n = 1'b1; sd_rd_ready = 0; sd_busy = 0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      if (p0_ack || p1_ack || p0_rdata != 16'h0) ok = 1'b0;
    end
    chk("rst_no_ack", ok, 1'b1);
    p0_req = 1; p1_req = 1; p0_we = 0; p1_we = 0;
    step;
    chk("rst_first_grant_p0", {sd_rd_enable, sd_rd_addr}, {1'b1, 24'h10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
